// File: rtl/adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding and nibble width.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLE_W = 4;

endpackage

// File: rtl/carry_look_ahead_4.sv
// 4-bit carry-lookahead adder slice; purely combinational.
module carry_look_ahead_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit CLA step per cycle, valid/ready handshakes on both sides.
// Optional subtract mode (sub port) enabled by NIBBLE_SERIAL_ADDER_SUB_EN.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NIB  = WIDTH / NIBBLE_W;
    localparam int unsigned CW   = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CW+1:0]   idx;
    logic [3:0]      nib_s;
    logic            nib_c;
    logic            accept;
    logic            last_step;

    assign idx       = {cnt, 2'b00};
    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (cnt == LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    carry_look_ahead_4 u_cla (
        .a    (a_r[idx +: NIBBLE_W]),
        .b    (b_r[idx +: NIBBLE_W]),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is folded into the captured operands: B is inverted and the carry seeded with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_r   <= a;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
`else
            b_r   <= b;
            carry <= cin;
`endif
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == RUN) begin
            sum[idx +: NIBBLE_W] <= nib_s;
            carry <= nib_c;
            cnt   <= cnt + 1'b1;
            if (last_step) cout <= nib_c;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): vector table, corner sequences, random ops.
module tb_nibble_serial_adder;

    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic         vs;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-word arithmetic, carry/no-borrow is bit W.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    task automatic accept(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic vs);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        a        = va;
        b        = vb;
        cin      = vc;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub      = vs;
`else
        if (vs) $display("note: subtract vector skipped in add-only build");
`endif
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub      = 1'($urandom);
`endif
    endtask

    task automatic finish_op(input string name, input logic [W-1:0] es, input logic ec,
                             input int lat0);
        int lat = lat0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_latency"}, lat, NIB);
        check({name, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_back_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0]   r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;
        logic [W-1:0] held_s;
        logic         held_c;
        int           guard;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        tbl.push_back('{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0});
        tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        tbl.push_back('{16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0});
        tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
        tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
        tbl.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        tbl.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        tbl.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
        tbl.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
`endif

        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);

        // Mid-run view: sum cleared on accept, then nibble 0 written after first step.
        accept(16'h1234, 16'h1111, 1'b0, 1'b0);
        check("run_cleared_sum", {16'd0, sum}, 32'd0);
        check("run_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("run_step0_sum", {16'd0, sum}, 32'h0005);
        check("run_step0_valid", {31'd0, out_valid}, 32'd0);
        finish_op("seq1", 16'h2345, 1'b0, 1);

        foreach (tbl[i]) begin
            accept(tbl[i].va, tbl[i].vb, tbl[i].vc, tbl[i].vs);
            finish_op($sformatf("vec%0d", i), tbl[i].es, tbl[i].ec, 0);
        end

        // Backpressure in DONE while new operands are offered.
        accept(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        guard = 0;
        while (!out_valid && guard < 20) begin
            step();
            guard++;
        end
        check("hold_latency", guard, NIB);
        held_s   = sum;
        held_c   = cout;
        check("hold_sum0", {16'd0, held_s}, 32'h1000);
        check("hold_cout0", {31'd0, held_c}, 32'd0);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            step();
            check("hold_sum", {16'd0, sum}, {16'd0, held_s});
            check("hold_cout", {31'd0, cout}, {31'd0, held_c});
            check("hold_flags", {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        step();
        check("release_idle", {30'd0, out_valid, in_ready}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        check("release_no_accept", {30'd0, out_valid, in_ready}, 32'd1);

        // Asynchronous reset two steps into an operation.
        accept(16'hABCD, 16'h1357, 1'b0, 1'b0);
        step();
        step();
        check("abort_partial_sum", {16'd0, sum}, 32'h0024);
        rst = 1'b1;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        accept(16'h0001, 16'h0001, 1'b0, 1'b0);
        finish_op("after_abort", 16'h0002, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            r = model(ra, rb, rc, rs);
            accept(ra, rb, rc, rs);
            finish_op($sformatf("rand%0d", n), r[W-1:0], r[W], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
